// File: rtl/i2s_axis_packetizer_if.sv
// AXI-Stream bundle for the I2S packetizer output.
//   tvalid/tdata/tstrb/tlast : driven by the master (packetizer)
//   tready                   : driven by the slave (downstream sink)
interface i2s_axis_packetizer_if #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32
);
  logic                              tvalid;
  logic                              tready;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] tstrb;
  logic                              tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/i2s_axis_packetizer.sv
// Reads fixed-size bursts from an I2S sample FIFO and emits them as AXI-Stream packets.
// Optional feature macro: I2S_AXIS_HEADER_EN (prepends {16'hA55A, seq} header beat).
//   clk, rst_n   : clock, synchronous active-low reset
//   rdata        : FIFO read data, valid the cycle after r_enable
//   r_ready      : FIFO holds at least BULK_OF_DATA words
//   error_empty  : FIFO underflow flag
//   r_enable     : FIFO read strobe, one word per high cycle
//   m_axis       : AXI-Stream master (tvalid/tready/tdata/tstrb/tlast)
//   packet_count : packets fully accepted downstream (wrapping)
//   stream_error : sticky, underflow seen during a burst
module i2s_axis_packetizer #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BULK_OF_DATA         = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] rdata,
  input  logic                            r_ready,
  input  logic                            error_empty,
  output logic                            r_enable,
  i2s_axis_packetizer_if.master           m_axis,
  output logic [15:0]                     packet_count,
  output logic                            stream_error
);
  localparam int unsigned DataW = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned LeftW = $clog2(BULK_OF_DATA + 1);

`ifdef I2S_AXIS_HEADER_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StHeader = 2'd1, StBurst = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StBurst = 2'd2} state_e;
`endif

  state_e           state_q;
  logic [LeftW-1:0] left_q;       // reads still to issue this packet
  logic             pend_q;       // read issued last cycle, data on rdata now
  logic             pend_last_q;  // that read was the packet's final word
  logic [1:0]       cnt_q;        // buffer occupancy
  logic [DataW-1:0] buf0_q, buf1_q;
  logic             last0_q, last1_q;
`ifdef I2S_AXIS_HEADER_EN
  logic [15:0]      seq_q;
`endif

  logic             pop, push, push_last, reading;
  logic [DataW-1:0] push_data;
  logic [2:0]       occ;

  assign m_axis.tvalid = (cnt_q != 2'd0);
  assign m_axis.tdata  = buf0_q;
  assign m_axis.tlast  = last0_q;
  assign m_axis.tstrb  = '1;
  assign pop           = m_axis.tvalid & m_axis.tready;

  always_comb begin
    // Occupancy counts the beat leaving this cycle so a read can overlap it; this is
    // what lets the 2-entry buffer sustain one beat per cycle.
    occ       = 3'(cnt_q) - 3'(pop) + 3'(pend_q);
`ifdef I2S_AXIS_HEADER_EN
    reading   = (state_q == StBurst) || (state_q == StHeader);
`else
    reading   = (state_q == StBurst);
`endif
    r_enable  = reading && (left_q != '0) && (occ < 3'd2);
    push      = pend_q;
    push_data = rdata;
    push_last = pend_last_q;
`ifdef I2S_AXIS_HEADER_EN
    // Buffer is empty and no read is pending while in HEADER.
    if (state_q == StHeader) begin
      push      = 1'b1;
      push_data = DataW'({16'hA55A, seq_q});
      push_last = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      left_q       <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      cnt_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      last0_q      <= 1'b0;
      last1_q      <= 1'b0;
      packet_count <= 16'd0;
      stream_error <= 1'b0;
`ifdef I2S_AXIS_HEADER_EN
      seq_q        <= 16'd0;
`endif
    end else begin
      pend_q      <= r_enable;
      pend_last_q <= r_enable && (left_q == LeftW'(1));
      if (r_enable) left_q <= left_q - LeftW'(1);

      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            buf0_q  <= push_data;
            last0_q <= push_last;
          end else begin
            buf1_q  <= push_data;
            last1_q <= push_last;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q  <= buf1_q;
          last0_q <= last1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_q  <= push_data;
            last0_q <= push_last;
          end else begin
            buf0_q  <= buf1_q;
            last0_q <= last1_q;
            buf1_q  <= push_data;
            last1_q <= push_last;
          end
        end
        default: ;
      endcase

      if ((state_q == StBurst) && error_empty) stream_error <= 1'b1;

      case (state_q)
        StIdle: begin
          if (r_ready) begin
            left_q  <= LeftW'(BULK_OF_DATA);
`ifdef I2S_AXIS_HEADER_EN
            state_q <= StHeader;
`else
            state_q <= StBurst;
`endif
          end
        end
`ifdef I2S_AXIS_HEADER_EN
        StHeader: begin
          state_q <= StBurst;
          seq_q   <= seq_q + 16'd1;
        end
`endif
        StBurst: begin
          if (pop && m_axis.tlast) begin
            state_q      <= StIdle;
            packet_count <= packet_count + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
